// File: rtl/mash_sequencer.sv
// mash_sequencer: holds each PCM sample on x_out for osr cycles with stage_en, handling prime, underrun and drain
module mash_sequencer #(
    parameter int DW = 4,
    parameter int OSR_W = 8
) (
    input  logic             clck,
    input  logic             rst,
    input  logic             run,
    input  logic [OSR_W-1:0] osr,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [DW-1:0]    x_out,
    output logic             stage_en,
    output logic             frame_start,
    output logic             underrun,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
    state_t           state;
    logic [OSR_W-1:0] cnt;
    logic [OSR_W-1:0] reload;
    logic [DW-1:0]    hold;
    logic             hold_full;
    logic             xfer;
    logic             bound;
    assign reload  = (osr == '0) ? '0 : osr - 1'b1;
    assign s_ready = (state == PRIME || state == RUN) && !hold_full;
    assign xfer    = s_valid && s_ready;
    assign bound   = cnt == '0;
    assign busy    = state != IDLE;
    always_ff @(posedge clck) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            x_out       <= '0;
            stage_en    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    state    <= PRIME;
                    underrun <= 1'b0;
                end
                PRIME: if (xfer) begin
                    x_out       <= s_data;
                    cnt         <= reload;
                    frame_start <= 1'b1;
                    stage_en    <= 1'b1;
                    state       <= RUN;
                end else if (!run) begin
                    state <= IDLE;
                end
                RUN: if (!bound) begin
                    cnt <= cnt - 1'b1;
                    if (xfer) begin
                        hold      <= s_data;
                        hold_full <= 1'b1;
                    end
                end else begin
                    cnt       <= reload;
                    hold_full <= 1'b0;
                    if (!run) begin
                        x_out <= '0;
                        state <= DRAIN;
                    end else begin
                        x_out       <= hold_full ? hold : xfer ? s_data : '0;
                        frame_start <= 1'b1;
                        if (!hold_full && !xfer) underrun <= 1'b1;
                    end
                end
                DRAIN: if (bound) begin
                    state    <= IDLE;
                    stage_en <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mash_sequencer.sv
// tb_mash_sequencer: directed and random checks of mash_sequencer against a frame-level model
module tb_mash_sequencer;
    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] osr;
    logic [3:0] sd;
    logic       sv;
    logic       s_ready;
    logic [3:0] x_out;
    logic       stage_en;
    logic       frame_start;
    logic       underrun;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    int         m_mode;
    int         m_left;
    logic [3:0] m_pend[$];
    logic [3:0] m_x;
    logic       m_en;
    logic       m_fs;
    logic       m_ur;
    logic       use_feed = 0;
    logic [3:0] feed[$];
    logic [3:0] e1[12] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'hE, 4'hE, 4'hE, 4'hE, 4'd5, 4'd5, 4'd5, 4'd5};

    mash_sequencer #(.DW(4), .OSR_W(8)) dut (
        .clck(clk), .rst(rst), .run(run), .osr(osr), .s_data(sd), .s_valid(sv),
        .s_ready(s_ready), .x_out(x_out), .stage_en(stage_en), .frame_start(frame_start),
        .underrun(underrun), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string n, logic [7:0] a, logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        logic rdy;
        logic xf;
        int   eff;
        if (use_feed) begin
            sv = feed.size() != 0;
            if (sv) sd = feed[0];
        end
        rdy = (m_mode == 1 || m_mode == 2) && m_pend.size() == 0;
        xf  = sv && rdy;
        eff = (osr == 0) ? 1 : int'(osr);
        @(posedge clk);
        m_fs = 0;
        if (rst) begin
            m_mode = 0; m_left = 0; m_pend.delete(); m_x = 0; m_en = 0; m_ur = 0;
        end else begin
            case (m_mode)
                0: if (run) begin m_mode = 1; m_ur = 0; end
                1: if (xf) begin
                    m_x = sd; m_left = eff; m_fs = 1; m_en = 1; m_mode = 2;
                end else if (!run) m_mode = 0;
                2: begin
                    m_left--;
                    if (m_left > 0) begin
                        if (xf) m_pend.push_back(sd);
                    end else begin
                        m_left = eff;
                        if (!run) begin
                            m_x = 0; m_pend.delete(); m_mode = 3;
                        end else begin
                            m_fs = 1;
                            if (m_pend.size() != 0) m_x = m_pend.pop_front();
                            else if (xf) m_x = sd;
                            else begin m_x = 0; m_ur = 1; end
                        end
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_en = 0; end
                end
            endcase
        end
        if (use_feed && xf) void'(feed.pop_front());
        @(negedge clk);
        chk("m_x_out", x_out, m_x);
        chk("m_stage_en", stage_en, m_en);
        chk("m_frame_start", frame_start, m_fs);
        chk("m_underrun", underrun, m_ur);
        chk("m_busy", busy, m_mode != 0);
        chk("m_s_ready", s_ready, (m_mode == 1 || m_mode == 2) && m_pend.size() == 0);
    endtask

    initial begin
        m_mode = 0; m_left = 0; m_x = 0; m_en = 0; m_fs = 0; m_ur = 0;
        rst = 1; run = 0; osr = 4; sv = 0; sd = 0;
        @(negedge clk);
        step(); step();
        chk("rst_x", x_out, 0); chk("rst_en", stage_en, 0); chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0); chk("rst_ur", underrun, 0); chk("rst_fs", frame_start, 0);
        rst = 0; run = 1;
        step();
        chk("prime_busy", busy, 1); chk("prime_en", stage_en, 0);
        use_feed = 1; feed = '{4'd3, 4'hE, 4'd5};
        for (int i = 0; i < 12; i++) begin
            run = i < 9;
            step();
            chk("s1_x", x_out, e1[i]); chk("s1_fs", frame_start, i % 4 == 0); chk("s1_ur", underrun, 0);
        end
        step();
        chk("drain_x", x_out, 0); chk("drain_en", stage_en, 1); chk("drain_busy", busy, 1);
        repeat (3) step();
        chk("drain_last_en", stage_en, 1);
        step();
        chk("idle_en", stage_en, 0); chk("idle_busy", busy, 0);
        use_feed = 0; osr = 0; run = 1; sv = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            sv = 1; sd = 4'(i);
            step();
            chk("s2_x", x_out, i); chk("s2_ready", s_ready, 1); chk("s2_fs", frame_start, 1);
        end
        run = 0; sv = 0;
        step(); step();
        chk("s2_idle", busy, 0);
        osr = 3; run = 1;
        step();
        sv = 1; sd = 7;
        step();
        chk("s3_x0", x_out, 7); chk("s3_fs0", frame_start, 1);
        sv = 0;
        step(); step();
        chk("s3_x2", x_out, 7); chk("s3_ur2", underrun, 0);
        step();
        chk("s3_x3", x_out, 0); chk("s3_ur3", underrun, 1); chk("s3_fs3", frame_start, 1);
        step(); step();
        chk("s3_fs5", frame_start, 0);
        step();
        chk("s3_fs6", frame_start, 1);
        run = 0;
        repeat (8) step();
        chk("s3_idle", busy, 0); chk("s3_sticky", underrun, 1);
        run = 1;
        step();
        chk("s3_clr", underrun, 0); chk("s3_prime", busy, 1);
        osr = 4; use_feed = 1; feed = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        for (int i = 0; i < 9; i++) begin
            if (i == 1) osr = 2;
            step();
            chk("s5_fs", frame_start, i == 0 || i == 4 || i == 6 || i == 8);
        end
        step();
        chk("s6_full", s_ready, 0);
        rst = 1;
        step();
        chk("s6_x", x_out, 0); chk("s6_en", stage_en, 0); chk("s6_busy", busy, 0);
        chk("s6_ready", s_ready, 0); chk("s6_fs", frame_start, 0); chk("s6_ur", underrun, 0);
        rst = 0; use_feed = 0; feed.delete(); sv = 0;
        step();
        chk("s6_prime", busy, 1); chk("s6_prime_ready", s_ready, 1);
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            run = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 15) == 0) osr = 8'($urandom_range(0, 6));
            sv = $urandom_range(0, 2) != 0;
            sd = 4'($urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mash_sequencer.md
# mash_sequencer

Sample-rate sequencer for the MASH sigma-delta DAC datapath. It accepts signed PCM samples over a valid/ready handshake, holds each sample on the modulator input for a programmable oversampling ratio (OSR) of clock cycles, and gates the truncator stages with a stage enable. It handles start-up priming, underrun substitution, and a controlled drain that flushes the truncator error registers with zero input before stopping.

## Interface
- DW, 4, sample width, two's complement; matches the modulator input width.
- OSR_W, 8, width of the OSR programming port.

- clck  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 starts or continues conversion, 0 requests a stop at the next frame boundary.
- osr  in  OSR_W  modulator cycles per input sample. Value 0 is treated as 1. Sampled only at frame boundaries.
- s_data  in  DW  signed input sample.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  sequencer can accept a sample this cycle.
- x_out  out  DW  signed sample driven to the first truncator stage.
- stage_en  out  1  clock enable for all truncator stages.
- frame_start  out  1  one-cycle pulse on the first cycle of every frame.
- underrun  out  1  sticky flag; cleared by rst or by an IDLE→PRIME transition.
- busy  out  1  high in any state except IDLE.

## Operation
- A transfer occurs on a rising edge with s_valid && s_ready.
- Effective ratio: osr_eff = max(osr, 1), latched into osr_q when a frame loads.
- Frame counter cnt counts down from osr_eff-1 to 0. The boundary is cnt==0 in RUN.
- Holding buffer: one entry (buf, buf_full). s_ready = (state==PRIME || state==RUN) && !buf_full.
- State machine:
  - IDLE: x_out=0, stage_en=0, buffer empty. run=1 → PRIME; underrun is cleared.
  - PRIME: stage_en=0. A transfer loads x_out=s_data, cnt=osr_eff-1, sets frame_start, and moves to RUN. If run=0 with no transfer, → IDLE.
  - RUN: stage_en=1. cnt decrements each cycle. A transfer with cnt≠0 fills buf. At the boundary, the first matching case applies:
    - run=0: x_out=0, cnt=osr_eff-1, buffer discarded, → DRAIN.
    - buf_full: x_out=buf, buf_full=0, frame_start=1.
    - A transfer in the same cycle (bypass): x_out=s_data, frame_start=1. This is not an underrun.
    - Otherwise (underrun): x_out=0, underrun=1, frame_start=1, and the frame length is still honoured.
  - DRAIN: x_out=0, stage_en=1, s_ready=0 for osr_eff cycles so the truncator error registers flush. Then → IDLE. Raising run during DRAIN has no effect until IDLE is reached.
- No arithmetic is performed on samples; they pass through bit-exact. The counter wraps only by reload, never by underflow.
- A change on osr in mid-frame has no effect until the next load.

## Timing
- Reset values: state=IDLE, x_out=0, stage_en=0, s_ready=0, frame_start=0, underrun=0, busy=0, buf_full=0, cnt=0.
- A reset asserted in any state takes effect at the next edge. In-flight samples are discarded with no drain.
- Latency from a PRIME transfer to x_out and stage_en being valid: 1 cycle.
- Frame length: exactly osr_eff cycles of stage_en=1 per sample. frame_start is spaced osr_eff cycles apart in steady state.
- With osr_eff=1, every RUN cycle is a boundary. s_ready stays high, samples flow through bypass at 1 sample per cycle, and buf is never used.
- Stop latency: run falling is observed only at a boundary. The total is the remainder of the current frame, plus osr_eff DRAIN cycles, plus 1 cycle to IDLE.
- The outputs of this block are registered. The truncator sees x_out and stage_en on the same edge.

## Test plan
- Reset, then run=1, osr=4, samples 3, -2, 5 offered back-to-back → x_out holds 3, -2, 5 for 4 cycles each. frame_start pulses every 4 cycles. underrun stays 0.
- osr=0, run=1, s_valid held high with an incrementing sample → behaves as osr=1. x_out updates every cycle. s_ready stays 1 and buf_full stays 0.
- osr=3, one sample (7) is sent and then s_valid drops → after 3 cycles x_out=0, underrun=1, and frame_start keeps pulsing every 3 cycles.
- osr=4 in RUN, run dropped mid-frame → the frame completes. The state then spends 4 DRAIN cycles with x_out=0 and stage_en=1, then IDLE with busy=0 and stage_en=0.
- osr changed from 4 to 2 mid-frame → the current frame stays 4 cycles and subsequent frames are 2 cycles.
- rst pulsed in the middle of RUN with buf_full=1 → on the next cycle all outputs are at their reset values. A following run=1 goes through PRIME with underrun cleared.
